regfile_wb_arbiter: RTL

//  Shares the register file's single write port between two writeback requesters (ALU, LSU).

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_scoreboard.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Package rf_ctrl_pkg: shared widths, types and helpers for the register
// file writeback arbiter slice.
//   XLEN : data width of a register
//   NREG : number of architectural registers (x0 hard-wired zero)
//   AW   : register address width
package rf_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef logic [AW-1:0]   regaddr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  localparam regaddr_t REG_ZERO = '0;

  function automatic req_e req_other(input req_e r);
    return (r == REQ_ALU) ? REQ_LSU : REQ_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, LSU), the arbiter and the
// register file write port.
//   alu_valid/alu_ready/alu_addr/alu_data : ALU writeback handshake
//   lsu_valid/lsu_ready/lsu_addr/lsu_data : LSU writeback handshake
//   rf_we/rf_waddr/rf_wdata               : register file write port
// Modports:
//   master : requester / register file side (drives valids, sees readies)
//   slave  : arbiter side
interface regfile_wb_arbiter_if;
  import rf_ctrl_pkg::*;

  logic     alu_valid;
  logic     alu_ready;
  regaddr_t alu_addr;
  word_t    alu_data;
  logic     lsu_valid;
  logic     lsu_ready;
  regaddr_t lsu_addr;
  word_t    lsu_data;
  logic     rf_we;
  regaddr_t rf_waddr;
  word_t    rf_wdata;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// rf_scoreboard: per-register busy bits for RAW hazard detection.
//   clk, rst_n           : clock, async active-low reset
//   set_en, set_addr     : a producer for set_addr was issued
//   clr_en, clr_addr     : the register file commits clr_addr this edge
//   chk_addr_1/2         : source registers to look up
//   chk_busy_1/2         : lookup results (combinational)
//   busy_vec             : full scoreboard, bit 0 always 0
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  regaddr_t        set_addr,
  input  logic            clr_en,
  input  regaddr_t        clr_addr,
  input  regaddr_t        chk_addr_1,
  input  regaddr_t        chk_addr_2,
  output logic            chk_busy_1,
  output logic            chk_busy_2,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear is applied before set so a newer producer issued on the commit
  // edge of an older one keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (clr_en && (clr_addr == regaddr_t'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_addr == regaddr_t'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec   = busy_q;
  assign chk_busy_1 = busy_q[chk_addr_1];
  assign chk_busy_2 = busy_q[chk_addr_2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// and LSU writeback paths with round-robin arbitration, a one-cycle
// registered write stage and a busy scoreboard for RAW hazard checks.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : ALU/LSU writeback handshakes and rf write port
//   iss_valid/addr    : decode issuing a producer of iss_addr
//   chk_addr_1/2      : source registers to hazard-check
//   chk_busy_1/2      : outstanding producer on chk_addr_n
//   busy_vec          : full scoreboard
// Optional macro RF_WB_BYPASS_EN adds byp_hit_1/2 and byp_data_1/2, which
// forward the staged write to decode and mask chk_busy_n on a hit.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus,
  input  logic                iss_valid,
  input  regaddr_t            iss_addr,
  input  regaddr_t            chk_addr_1,
  input  regaddr_t            chk_addr_2,
  output logic                chk_busy_1,
  output logic                chk_busy_2,
`ifdef RF_WB_BYPASS_EN
  output logic                byp_hit_1,
  output logic                byp_hit_2,
  output word_t               byp_data_1,
  output word_t               byp_data_2,
`endif
  output logic [NREG-1:0]     busy_vec
);

  req_e     rr_q, rr_d, grant;
  logic     both, xfer;
  regaddr_t sel_addr;
  word_t    sel_data;
  logic     we_q;
  regaddr_t waddr_q;
  word_t    wdata_q;
  logic     raw_busy_1, raw_busy_2;

  always_comb begin
    both  = bus.alu_valid & bus.lsu_valid;
    xfer  = bus.alu_valid | bus.lsu_valid;
    grant = REQ_ALU;
    if (both)               grant = rr_q;
    else if (bus.lsu_valid) grant = REQ_LSU;
    rr_d = rr_q;
    if (both) rr_d = req_other(rr_q);
    sel_addr = (grant == REQ_LSU) ? bus.lsu_addr : bus.alu_addr;
    sel_data = (grant == REQ_LSU) ? bus.lsu_data : bus.alu_data;
  end

  assign bus.alu_ready = bus.alu_valid & (grant == REQ_ALU);
  assign bus.lsu_ready = bus.lsu_valid & (grant == REQ_LSU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= REQ_ALU;
    else        rr_q <= rr_d;
  end

  // x0 writes are accepted by the handshake but never reach the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= xfer & (sel_addr != REG_ZERO);
      if (xfer) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.rf_we    = we_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (iss_valid),
    .set_addr   (iss_addr),
    .clr_en     (we_q),
    .clr_addr   (waddr_q),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .chk_busy_1 (raw_busy_1),
    .chk_busy_2 (raw_busy_2),
    .busy_vec   (busy_vec)
  );

`ifdef RF_WB_BYPASS_EN
  assign byp_hit_1  = we_q & (waddr_q == chk_addr_1) & (chk_addr_1 != REG_ZERO);
  assign byp_hit_2  = we_q & (waddr_q == chk_addr_2) & (chk_addr_2 != REG_ZERO);
  assign byp_data_1 = wdata_q;
  assign byp_data_2 = wdata_q;
  assign chk_busy_1 = raw_busy_1 & ~byp_hit_1;
  assign chk_busy_2 = raw_busy_2 & ~byp_hit_2;
`else
  assign chk_busy_1 = raw_busy_1;
  assign chk_busy_2 = raw_busy_2;
`endif

endmodule
